// File: rtl/alu_issue.sv
// alu_issue: RV32I register-file and issue stage for an external ALU.
//
// It accepts one instruction at a time, decodes the OP and OP-IMM formats,
// reads the operands at accept, and holds them stable while the ALU works.
// It writes the ALU result back to rd and reports each outcome with a
// single-cycle pulse.
//
// Ports:
//   clk, rst               rising-edge clock; asynchronous active-low reset
//   instr, instr_valid     instruction word and its valid
//   instr_ready            high while idle and able to accept
//   lhs/rhs (+_valid)      ALU operands
//   operation (+_valid)    funct3 sent to the ALU
//   metadata (+_valid)     funct7 sent to the ALU (0x00 for non-shift OP-IMM)
//   result, result_valid   ALU result returned to this stage
//   retired/illegal/timeout  single-cycle status pulses
//   dbg_addr, dbg_data     combinational register-file read port
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] lhs,
  output logic        lhs_valid,
  output logic [31:0] rhs,
  output logic        rhs_valid,
  output logic [2:0]  operation,
  output logic        operation_valid,
  output logic [6:0]  metadata,
  output logic        metadata_valid,
  input  logic [31:0] result,
  input  logic        result_valid,
  output logic        retired,
  output logic        illegal,
  output logic        timeout,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] regs [32];
  logic [4:0]  rd_q;
  logic [3:0]  wait_cnt;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  logic        dec_legal;
  logic [31:0] dec_rhs;
  logic [6:0]  dec_meta;
  logic        accept;
  logic        timeout_hit;
  logic        write_en;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Decode legality and the second operand.
  // Shift immediates are zero-extended with funct7 passed through. Other
  // immediates are sign-extended with a zero funct7.
  always_comb begin
    dec_legal = 1'b0;
    dec_rhs   = 32'd0;
    dec_meta  = 7'd0;
    case (opcode)
      OPC_R: begin
        dec_rhs   = regs[rs2];
        dec_meta  = funct7;
        dec_legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      end
      OPC_I: begin
        if (funct3 == 3'd1 || funct3 == 3'd5) begin
          dec_rhs   = {27'd0, rs2};
          dec_meta  = funct7;
          dec_legal = (funct7 == 7'h00) || ((funct3 == 3'd5) && (funct7 == 7'h20));
        end else begin
          dec_rhs   = {{20{instr[31]}}, instr[31:20]};
          dec_meta  = 7'd0;
          dec_legal = 1'b1;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && instr_valid;

  // The counter holds the number of completed ISSUE cycles that had no
  // result. This cycle makes it reach 15 when it currently reads 14.
  assign timeout_hit = (wait_cnt == 4'd14);
  assign write_en    = (state == ISSUE) && result_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next      = state;
    instr_ready     = 1'b0;
    lhs_valid       = 1'b0;
    rhs_valid       = 1'b0;
    operation_valid = 1'b0;
    metadata_valid  = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && dec_legal) state_next = ISSUE;
      end
      ISSUE: begin
        lhs_valid       = 1'b1;
        rhs_valid       = 1'b1;
        operation_valid = 1'b1;
        metadata_valid  = 1'b1;
        if (result_valid || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands, destination latch, wait counter and status pulses.
  // A result that arrives in the 15th ISSUE cycle beats the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lhs       <= 32'd0;
      rhs       <= 32'd0;
      operation <= 3'd0;
      metadata  <= 7'd0;
      rd_q      <= 5'd0;
      wait_cnt  <= 4'd0;
      retired   <= 1'b0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      retired <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;
      if (accept) begin
        if (dec_legal) begin
          lhs       <= regs[rs1];
          rhs       <= dec_rhs;
          operation <= funct3;
          metadata  <= dec_meta;
          rd_q      <= rd;
          wait_cnt  <= 4'd0;
        end else begin
          illegal <= 1'b1;
        end
      end else if (state == ISSUE) begin
        if (result_valid) begin
          retired <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
          if (timeout_hit) timeout <= 1'b1;
        end
      end
    end
  end

  // Register file. x0 is never written, so it always reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (write_en && (rd_q != 5'd0)) begin
      regs[rd_q] <= result;
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL provide: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: instr  in  32  RV32I instruction word.
REQ-004 SHALL provide: instr_valid  in  1 / instr_ready  out  1  instruction handshake.
REQ-005 SHALL provide: lhs  out  32; lhs_valid  out  1  ALU left operand.
REQ-006 SHALL provide: rhs  out  32; rhs_valid  out  1  ALU right operand.
REQ-007 SHALL provide: operation  out  [14:12]; operation_valid  out  1  funct3 to ALU.
REQ-008 SHALL provide: metadata  out  [31:25]; metadata_valid  out  1  funct7 to ALU.
REQ-009 SHALL provide: result  in  32; result_valid  in  1  ALU result.
REQ-010 SHALL provide: retired  out  1, illegal  out  1, timeout  out  1  single-cycle status pulses.
REQ-011 SHALL provide: dbg_addr  in  5; dbg_data  out  32  combinational register-file read port.

Function
REQ-012 SHALL contain a 32x32 register file; x0 reads 0, and writes to x0 are discarded.
REQ-013 SHALL implement FSM states IDLE and ISSUE.
REQ-014 In IDLE: instr_ready=1 and all four *_valid outputs =0.
REQ-015 In ISSUE: instr_ready=0 and all four *_valid outputs =1.
REQ-016 Accept occurs on instr_valid&&instr_ready at a rising edge; register-file reads occur at accept; lhs/rhs/operation/metadata SHALL be registered and held stable throughout ISSUE.
REQ-017 R-type (opcode 0110011) SHALL issue lhs=x[rs1], rhs=x[rs2], operation=funct3, metadata=funct7.
REQ-018 R-type legality: funct7=0x00 is legal for any funct3; funct7=0x20 is legal only with funct3 0 or 5; every other funct7 is illegal.
REQ-019 I-type (opcode 0010011), non-shift: lhs=x[rs1], rhs=sign-extended instr[31:20], operation=funct3, metadata=0x00.
REQ-020 I-type shifts: for funct3=1, funct7 must be 0x00; for funct3=5, funct7 must be 0x00 or 0x20. rhs=zero-extended instr[24:20], metadata=instr[31:25].
REQ-021 Any other opcode, or an illegal funct7, SHALL pulse illegal for 1 cycle on the cycle after accept, remain in IDLE and write nothing.
REQ-022 IDLE->ISSUE on accept of a legal instruction; latch rd.
REQ-023 In ISSUE, on result_valid=1: write result to x[rd] at that edge, pulse retired the next cycle, return to IDLE.
REQ-024 Minimum occupancy is 2 cycles per instruction (accept plus one ISSUE cycle); the following instruction observes the written value, so no bypass is required.
REQ-025 A 4-bit timeout counter SHALL clear on entry to ISSUE and increment each ISSUE cycle without result_valid.
REQ-026 When the counter reaches 15 without result_valid: pulse timeout, return to IDLE, perform no write.
REQ-027 If result_valid and the counter reaching 15 occur in the same cycle, result_valid SHALL win (write and retire, no timeout).
REQ-028 result_valid SHALL be ignored while in IDLE.
REQ-029 The register-file write SHALL complete at the edge that leaves ISSUE; a dbg_data read in the same cycle SHALL return the old value.

Reset
REQ-030 rst=0 SHALL asynchronously force: IDLE state, all registers x1-x31=0, all operand/valid outputs=0, status pulses=0, timeout counter=0.
REQ-031 Outputs SHALL reflect the reset state within the same cycle as rst assertion; the first accept is permitted on the first rising edge with rst=1.
REQ-032 Reset asserted during ISSUE SHALL abandon the instruction with no write and no pulse.

Verification
REQ-033 With a 1-cycle ALU model: 0x00500093 (addi x1,x0,5), then 0x00300113 (addi x2,x0,3) -> dbg x1=5, x2=3; each issues metadata=0x00.
REQ-034 0x002081B3 (add x3,x1,x2) -> issue lhs=5, rhs=3, op=0, metadata=0x00; x3=8. Then 0x40208233 (sub x4,x1,x2) -> metadata=0x20; x4=2.
REQ-035 x1=0xA863201F, then 0x4040D293 (srai x5,x1,4) -> rhs=4, op=5, metadata=0x20; x5=0xFA863201.
REQ-036 0x022081B3 (funct7=0x01) and 0x00002003 (load opcode) -> one illegal pulse each, no valids raised, x3 unchanged.
REQ-037 Legal instruction with result_valid held 0 -> timeout pulses after 15 ISSUE cycles, no write; rst=0 pulsed mid-ISSUE -> all valids 0 immediately, all registers read 0.
